// File: rtl/bcd_to_bin_seq_if.sv
// Handshake and data bundle for the sequential 3-digit BCD to binary converter.
// The requester drives start and the digits; the converter returns busy/done/bin_out/err.
`timescale 1ns/1ps
interface bcd_to_bin_seq_if;
   logic       start;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       busy;
   logic       done;
   logic [9:0] bin_out;
   logic       err;

   modport master (
      output start, hundreds, tens, ones,
      input  busy, done, bin_out, err
   );

   modport slave (
      input  start, hundreds, tens, ones,
      output busy, done, bin_out, err
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, 10 shift cycles).
// Define BCD2BIN_DIGIT_CHK_EN to flag digits above 9 on err and skip the conversion.
`timescale 1ns/1ps
module bcd_to_bin_seq (
   input  logic            clk,
   input  logic            rst_n,
   bcd_to_bin_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t      state;
   logic [11:0] bcd_reg;
   logic [9:0]  bin_reg;
   logic [3:0]  cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [9:0]  bin_out_reg;

   logic [21:0] shifted;
   logic [11:0] bcd_adj;

   // One right shift of the combined register, then each BCD nibble that
   // picked up a carried-in 8 is corrected by subtracting 3.
   assign shifted = {bcd_reg, bin_reg} >> 1;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib                = shifted[10 + 4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
      end
   endgenerate

`ifdef BCD2BIN_DIGIT_CHK_EN
   logic err_reg;
   logic digits_bad;

   assign digits_bad = (bus.hundreds > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);
   assign bus.err    = err_reg;
`else
   assign bus.err    = 1'b0;
`endif

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.bin_out = bin_out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_reg     <= 12'd0;
         bin_reg     <= 10'd0;
         cnt_reg     <= 4'd0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         bin_out_reg <= 10'd0;
`ifdef BCD2BIN_DIGIT_CHK_EN
         err_reg     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  bcd_reg  <= {bus.hundreds, bus.tens, bus.ones};
                  bin_reg  <= 10'd0;
                  cnt_reg  <= 4'd0;
                  busy_reg <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHK_EN
                  // A bad request keeps err as is; it is (re)asserted with done.
                  if (digits_bad) begin
                     state <= FIN;
                  end else begin
                     err_reg <= 1'b0;
                     state   <= SHIFT;
                  end
`else
                  state <= SHIFT;
`endif
               end
            end

            SHIFT: begin
               bcd_reg <= bcd_adj;
               bin_reg <= shifted[9:0];
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == 4'd9) begin
                  // Tenth shift: publish the result so done lands in the FIN cycle.
                  state       <= FIN;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  bin_out_reg <= shifted[9:0];
               end
            end

            FIN: begin
               if (done_reg) begin
                  done_reg <= 1'b0;
                  state    <= IDLE;
               end else begin
                  // Entered straight from IDLE on a rejected request.
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  bin_out_reg <= 10'd0;
`ifdef BCD2BIN_DIGIT_CHK_EN
                  err_reg     <= 1'b1;
`endif
               end
            end

            default: begin
               state    <= IDLE;
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: scoreboard of expected results, one task per scenario.
// Build with BCD2BIN_DIGIT_CHK_EN defined to exercise the invalid-digit path.
`timescale 1ns/1ps
module tb_bcd_to_bin_seq;

   logic clk = 1'b0;
   logic rst_n;

   bcd_to_bin_seq_if bus ();

   bcd_to_bin_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // cyc equals the number of rising edges seen; stable when sampled on the falling edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0] bin;
      logic       err;
      int         at;
      bit         chk_bin;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Drive a request at a falling edge; the next rising edge accepts it.
   task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                        input bit hold, output int acc);
      exp_t e;
      bus.hundreds = h;
      bus.tens     = t;
      bus.ones     = o;
      bus.start    = 1'b1;
      acc       = cyc + 1;
      e.bin     = 10'(int'(h) * 100 + int'(t) * 10 + int'(o));
      e.err     = 1'b0;
      e.at      = acc + 10;
      e.chk_bin = 1'b1;
      if (h > 4'd9 || t > 4'd9 || o > 4'd9) begin
`ifdef BCD2BIN_DIGIT_CHK_EN
         e.bin = 10'd0;
         e.err = 1'b1;
         e.at  = acc + 1;
`else
         e.chk_bin = 1'b0;
`endif
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
   endtask

   // Bounded wait for the next done pulse; reports what was seen, compares nothing.
   task automatic wait_done(input int budget, output bit got, output int at,
                            output logic [9:0] b, output logic er);
      got = 1'b0;
      at  = -1;
      b   = 10'd0;
      er  = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            got = 1'b1;
            at  = cyc;
            b   = bus.bin_out;
            er  = bus.err;
         end
      end
   endtask

   task automatic test_reset();
      bus.start    = 1'b0;
      bus.hundreds = 4'd0;
      bus.tens     = 4'd0;
      bus.ones     = 4'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b req=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b req=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b req=0", bus.err); end
      checks++; if (bus.bin_out !== 10'd0) begin failures++; $display("FAIL reset_bin got=%0d req=0", bus.bin_out); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("txn reset: outputs cleared without a clock edge");
   endtask

   task automatic test_zero();
      exp_t e; bit got; int at, acc; logic [9:0] b; logic er;
      @(negedge clk);
      issue(4'd0, 4'd0, 4'd0, 1'b0, acc);
      wait_done(20, got, at, b, er);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
         failures++; $display("FAIL zero_timeout got=no_done req=done_at_%0d", e.at);
      end else begin
         checks++; if (at !== e.at) begin failures++; $display("FAIL zero_latency got=%0d req=%0d", at, e.at); end
         checks++; if (b !== e.bin) begin failures++; $display("FAIL zero_bin got=%0d req=%0d", b, e.bin); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL zero_err got=%b req=%b", er, e.err); end
      end
      $display("txn zero: digits=0,0,0 bin_out=%0d expected=%0d at=%0d", b, e.bin, at - acc);
   endtask

   task automatic test_max();
      exp_t e; int acc; logic exp_busy, exp_done;
      @(negedge clk);
      issue(4'd9, 4'd9, 4'd9, 1'b0, acc);
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) @(negedge clk);
         exp_busy = (k <= 9);
         exp_done = (k == 10);
         checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL max_busy k=%0d got=%b req=%b", k, bus.busy, exp_busy); end
         checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL max_done k=%0d got=%b req=%b", k, bus.done, exp_done); end
      end
      e = exp_q.pop_front();
      checks++; if (bus.bin_out !== e.bin) begin failures++; $display("FAIL max_bin got=%0d req=%0d", bus.bin_out, e.bin); end
      checks++; if (cyc !== e.at) begin failures++; $display("FAIL max_latency got=%0d req=%0d", cyc, e.at); end
      $display("txn max: digits=9,9,9 bin_out=%0d expected=%0d", bus.bin_out, e.bin);
   endtask

   task automatic test_ignore();
      exp_t e; int acc, dones, first_at; logic [9:0] first_bin;
      dones = 0; first_at = -1; first_bin = 10'd0;
      @(negedge clk);
      issue(4'd2, 4'd5, 4'd5, 1'b0, acc);
      repeat (3) @(negedge clk);
      bus.hundreds = 4'd1;
      bus.tens     = 4'd2;
      bus.ones     = 4'd3;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (dones == 0) begin first_at = cyc; first_bin = bus.bin_out; end
            dones++;
         end
      end
      e = exp_q.pop_front();
      checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_count got=%0d req=1", dones); end
      checks++; if (first_bin !== e.bin) begin failures++; $display("FAIL ignore_bin got=%0d req=%0d", first_bin, e.bin); end
      checks++; if (first_at !== e.at) begin failures++; $display("FAIL ignore_latency got=%0d req=%0d", first_at, e.at); end
      $display("txn ignore: digits=2,5,5 bin_out=%0d expected=%0d dones=%0d", first_bin, e.bin, dones);
   endtask

   task automatic test_reset_abort();
      exp_t e; bit got; int at, acc, dones; logic [9:0] b; logic er;
      dones = 0;
      @(negedge clk);
      issue(4'd1, 4'd2, 4'd3, 1'b0, acc);
      void'(exp_q.pop_front());  // request is aborted by reset, nothing to expect
      repeat (5) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b req=0", bus.busy); end
      checks++; if (bus.bin_out !== 10'd0) begin failures++; $display("FAIL abort_bin got=%0d req=0", bus.bin_out); end
      repeat (2) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      rst_n = 1'b1;
      repeat (14) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL abort_spurious_done got=%0d req=0", dones); end
      issue(4'd0, 4'd4, 4'd2, 1'b0, acc);
      wait_done(20, got, at, b, er);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
         failures++; $display("FAIL abort_restart_timeout got=no_done req=done_at_%0d", e.at);
      end else begin
         checks++; if (at !== e.at) begin failures++; $display("FAIL abort_latency got=%0d req=%0d", at, e.at); end
         checks++; if (b !== e.bin) begin failures++; $display("FAIL abort_bin_restart got=%0d req=%0d", b, e.bin); end
      end
      $display("txn reset_abort: restart digits=0,4,2 bin_out=%0d expected=%0d", b, e.bin);
   endtask

   task automatic test_digit_chk();
      exp_t e; bit got; int at, acc; logic [9:0] b; logic er;
      @(negedge clk);
      issue(4'd0, 4'd10, 4'd1, 1'b0, acc);
      wait_done(20, got, at, b, er);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
         failures++; $display("FAIL chk_bad_timeout got=no_done req=done_at_%0d", e.at);
      end else begin
         checks++; if (at !== e.at) begin failures++; $display("FAIL chk_bad_latency got=%0d req=%0d", at, e.at); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL chk_bad_err got=%b req=%b", er, e.err); end
         if (e.chk_bin) begin
            checks++; if (b !== e.bin) begin failures++; $display("FAIL chk_bad_bin got=%0d req=%0d", b, e.bin); end
         end
      end
      $display("txn digit_chk: digits=0,10,1 err=%b expected_err=%b bin_out=%0d", er, e.err, b);
      repeat (3) @(negedge clk);
      checks++; if (bus.err !== e.err) begin failures++; $display("FAIL chk_err_hold got=%b req=%b", bus.err, e.err); end
      issue(4'd0, 4'd0, 4'd7, 1'b0, acc);
      wait_done(20, got, at, b, er);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
         failures++; $display("FAIL chk_good_timeout got=no_done req=done_at_%0d", e.at);
      end else begin
         checks++; if (er !== 1'b0) begin failures++; $display("FAIL chk_good_err got=%b req=0", er); end
         checks++; if (b !== e.bin) begin failures++; $display("FAIL chk_good_bin got=%0d req=%0d", b, e.bin); end
      end
      $display("txn digit_chk: digits=0,0,7 err=%b bin_out=%0d expected=%0d", er, b, e.bin);
   endtask

   task automatic test_hold();
      exp_t e; bit got; int at, acc, extra; logic [9:0] b; logic er;
      extra = 0;
      @(negedge clk);
      issue(4'd0, 4'd1, 4'd0, 1'b1, acc);
      for (int j = 1; j <= 2; j++) begin
         e.bin = 10'd10; e.err = 1'b0; e.at = acc + 10 + 12 * j; e.chk_bin = 1'b1;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 3; i++) begin
         wait_done(20, got, at, b, er);
         if (i == 2) bus.start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (!got) begin
            failures++; $display("FAIL hold_timeout idx=%0d got=no_done req=done_at_%0d", i, e.at);
         end else begin
            checks++; if (at !== e.at) begin failures++; $display("FAIL hold_period idx=%0d got=%0d req=%0d", i, at, e.at); end
            checks++; if (b !== e.bin) begin failures++; $display("FAIL hold_bin idx=%0d got=%0d req=%0d", i, b, e.bin); end
         end
         $display("txn hold[%0d]: digits=0,1,0 bin_out=%0d expected=%0d at=%0d", i, b, e.bin, at - acc);
      end
      bus.start = 1'b0;
      repeat (16) begin
         @(negedge clk);
         if (bus.done === 1'b1) extra++;
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL hold_release got=%0d req=0", extra); end
   endtask

   task automatic test_back_to_back();
      exp_t e; bit got; int at, acc; logic [9:0] b; logic er;
      logic [3:0] h, t, o;
      for (int n = 0; n < 8; n++) begin
         h = 4'($urandom_range(0, 9));
         t = 4'($urandom_range(0, 9));
         o = 4'($urandom_range(0, 9));
         @(negedge clk);
         issue(h, t, o, 1'b0, acc);
         wait_done(20, got, at, b, er);
         e = exp_q.pop_front();
         checks++;
         if (!got) begin
            failures++; $display("FAIL b2b_timeout idx=%0d got=no_done req=done_at_%0d", n, e.at);
         end else begin
            checks++; if (b !== e.bin) begin failures++; $display("FAIL b2b_bin idx=%0d got=%0d req=%0d", n, b, e.bin); end
            checks++; if (at !== e.at) begin failures++; $display("FAIL b2b_latency idx=%0d got=%0d req=%0d", n, at, e.at); end
         end
         $display("txn b2b[%0d]: digits=%0d,%0d,%0d bin_out=%0d expected=%0d", n, h, t, o, b, e.bin);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_ignore();
      test_reset_abort();
      test_digit_chk();
      test_hold();
      test_back_to_back();
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL scoreboard_leftover got=%0d req=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
